// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: op encodings, FSM state
// encoding and default datapath widths.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 32;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the shift arbiter.
//   master : requesters + result consumer (drive valid/op/a/b, rsp_ready)
//   slave  : the arbiter (drives reqN_ready and the rsp_* slot)
interface shift_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32
);
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [AMT_W-1:0] req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [AMT_W-1:0] req1_b;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: SLL / SRL / SRA, plus ROR when
// SHIFT_ARBITER_ROTATE_EN is defined (op=11 yields 0 otherwise).
// The full amount b is honoured: any b >= WIDTH saturates instead of
// wrapping on its low bits.
//   op     : operation select
//   a      : value to shift
//   b      : unsigned shift amount
//   result : shifted value
module shift_core import shift_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] b,
  output logic [WIDTH-1:0] result
);
  localparam int SH_W = $clog2(WIDTH);

  logic                    in_range;
  logic [SH_W-1:0]         sh;
  logic signed [WIDTH-1:0] sra_v;

  assign in_range = (b < AMT_W'(WIDTH));
  assign sh       = b[SH_W-1:0];
  // Kept in its own signed net so the arithmetic shift is not demoted to a
  // logical one by an unsigned ternary context.
  assign sra_v    = $signed(a) >>> sh;

`ifdef SHIFT_ARBITER_ROTATE_EN
  logic [AMT_W-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_dbl;
  assign rot_amt = b % AMT_W'(WIDTH);
  assign rot_dbl = {a, a} >> rot_amt;
`endif

  always_comb begin
    result = '0;
    case (op)
      SHIFT_OP_SLL: result = in_range ? (a << sh) : '0;
      SHIFT_OP_SRL: result = in_range ? (a >> sh) : '0;
      SHIFT_OP_SRA: result = in_range ? sra_v : {WIDTH{a[WIDTH-1]}};
`ifdef SHIFT_ARBITER_ROTATE_EN
      SHIFT_OP_ROR: result = rot_dbl[WIDTH-1:0];
`else
      SHIFT_OP_ROR: result = '0;
`endif
      default:      result = '0;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared shifter.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> DONE (hold
// result until rsp_ready). Grant in cycle T gives rsp_valid in T+2.
// Optional macro SHIFT_ARBITER_ROTATE_EN enables op=11 rotate-right.
//   clk, rst : clock, async active-high reset
//   bus      : shift_arbiter_if slave (req0/req1 handshakes, rsp slot)
module shift_arbiter import shift_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);
  state_t           state, state_nxt;
  logic [1:0]       req_valid, grant;
  logic             last_grant, id_q, rsp_valid_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, result, rsp_data_q;
  logic [AMT_W-1:0] b_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|grant)        state_nxt = ST_EXEC;
      ST_EXEC:                    state_nxt = ST_DONE;
      ST_DONE: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: grant is only offered in IDLE. Gated by rst so ready reads 0
  // while reset is held, even with a requester already valid.
  always_comb begin
    grant = 2'b00;
    if (state == ST_IDLE && !rst) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = rsp_data_q;

  shift_core #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result)
  );

  // Operand capture and response slot. id_q doubles as rsp_id: it only
  // changes on a grant, which cannot happen while the slot is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (|grant) begin
        op_q       <= grant[1] ? bus.req1_op : bus.req0_op;
        a_q        <= grant[1] ? bus.req1_a  : bus.req0_a;
        b_q        <= grant[1] ? bus.req1_b  : bus.req0_b;
        id_q       <= grant[1];
        last_grant <= grant[1];
      end
      if (state == ST_EXEC) begin
        rsp_data_q  <= result;
        rsp_valid_q <= 1'b1;
      end else if (state == ST_DONE && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: latency, arbitration order, amount
// saturation, backpressure, async reset and op=11 in either build.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

`ifdef SHIFT_ARBITER_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h1000_000F;
`else
  localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  shift_arbiter_if #(.WIDTH(32), .AMT_W(32)) bus ();

  shift_arbiter #(.WIDTH(32), .AMT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single req0 operation: ready in T, rsp_valid in T+2, then handshake.
  task automatic single_op(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    #1 chk({tag, "_rdy"}, 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    #1 chk({tag, "_t1"}, 32'(bus.rsp_valid), 32'd0);
    step();
    chk({tag, "_t2"},  32'(bus.rsp_valid), 32'd1);
    chk({tag, "_dat"}, bus.rsp_data, exp);
    chk({tag, "_id"},  32'(bus.rsp_id), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    #1 chk({tag, "_clr"}, 32'(bus.rsp_valid), 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] held;
    idle_inputs();
    bus.req0_valid = 1'b1;  // ready must stay low while reset is held
    @(posedge clk);
    #1;
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("rst_vld",   32'(bus.rsp_valid),  32'd0);
    chk("rst_id",    32'(bus.rsp_id),     32'd0);
    chk("rst_data",  bus.rsp_data,        32'd0);
    do_reset();

    // 1: basic SLL latency
    single_op("sll1", SHIFT_OP_SLL, 32'h0000_0001, 32'd4, 32'h0000_0010);

    // 2: contention after reset, rsp_ready held high
    do_reset();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = SHIFT_OP_SRL; bus.req0_a = 32'h8000_0000; bus.req0_b = 32'd31;
    bus.req1_valid = 1'b1; bus.req1_op = SHIFT_OP_SRA; bus.req1_a = 32'h8000_0000; bus.req1_b = 32'd4;
    #1 chk("arb_g0_r0", 32'(bus.req0_ready), 32'd1);
    chk("arb_g0_r1", 32'(bus.req1_ready), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("arb_v0",   32'(bus.rsp_valid), 32'd1);
    chk("arb_d0",   bus.rsp_data, 32'h0000_0001);
    chk("arb_id0",  32'(bus.rsp_id), 32'd0);
    chk("arb_nog",  32'(bus.req1_ready), 32'd0);
    step();
    chk("arb_g1",   32'(bus.req1_ready), 32'd1);
    chk("arb_clr",  32'(bus.rsp_valid), 32'd0);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("arb_d1",   bus.rsp_data, 32'hF800_0000);
    chk("arb_id1",  32'(bus.rsp_id), 32'd1);
    step();
    bus.rsp_ready = 1'b0;
    step();

    // 3: amount boundaries and other patterns
    single_op("sll32",  SHIFT_OP_SLL, 32'hFFFF_FFFF, 32'd32,  32'h0000_0000);
    single_op("sra100", SHIFT_OP_SRA, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF);
    single_op("sra40",  SHIFT_OP_SRA, 32'h7FFF_FFFF, 32'd40,  32'h0000_0000);
    single_op("srl0",   SHIFT_OP_SRL, 32'hA5A5_1234, 32'd0,   32'hA5A5_1234);
    single_op("sll31",  SHIFT_OP_SLL, 32'h0000_0003, 32'd31,  32'h8000_0000);
    single_op("srlbig", SHIFT_OP_SRL, 32'hFFFF_FFFF, 32'h1000_0001, 32'h0000_0000);

    // 4: backpressure with req1 waiting
    bus.req0_valid = 1'b1; bus.req0_op = SHIFT_OP_SRL; bus.req0_a = 32'hF000_0000; bus.req0_b = 32'd8;
    step();
    bus.req0_valid = 1'b0;
    step();
    bus.req1_valid = 1'b1; bus.req1_op = SHIFT_OP_SLL; bus.req1_a = 32'h0000_00FF; bus.req1_b = 32'd8;
    held = bus.rsp_data;
    chk("bp_dat0", held, 32'h00F0_0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_vld", 32'(bus.rsp_valid), 32'd1);
      chk("bp_dat", bus.rsp_data, 32'h00F0_0000);
      chk("bp_id",  32'(bus.rsp_id), 32'd0);
      chk("bp_rdy", 32'(bus.req1_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_hs_rdy", 32'(bus.req1_ready), 32'd0);
    step();
    bus.rsp_ready = 1'b0;
    #1 chk("bp_g1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("bp_d1",  bus.rsp_data, 32'h0000_FF00);
    chk("bp_id1", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    step();

    // 5: async reset while DONE; req0 served last so only reset restores
    // last_grant and hands the next contention to req0.
    bus.req0_valid = 1'b1; bus.req0_op = SHIFT_OP_SLL; bus.req0_a = 32'h1; bus.req0_b = 32'd1;
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("ar_vld", 32'(bus.rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk("ar_async", 32'(bus.rsp_valid), 32'd0);
    chk("ar_data", bus.rsp_data, 32'd0);
    #1 rst = 1'b0;
    step();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1 chk("ar_g0", 32'(bus.req0_ready), 32'd1);
    chk("ar_g1", 32'(bus.req1_ready), 32'd0);
    do_reset();

    // 6: op=11, including an amount beyond WIDTH
    single_op("ror4",  SHIFT_OP_ROR, 32'h0000_00F1, 32'd4,  ROR_EXP);
    single_op("ror36", SHIFT_OP_ROR, 32'h0000_00F1, 32'd36, ROR_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
